nibble_capture: RTL
===================

Name: nibble_capture

Overview:
- Upstream input stage for the DE2 switch-driven display chain (e.g. the even/odd seven-segment stage).
- Synchronizes and debounces one pushbutton (KEY, active-low).
- On each debounced press, latches the synchronized slide-switch nibble and presents it with a valid/ready handshake.
- Gives downstream combinational stages a stable operand that changes only on deliberate user action.

Parameters:
- WIDTH, 4, number of switch bits captured.
- SYNC_STAGES, 2, flip-flop depth of the synchronizer on key_n and sw (legal range 2..3).
- DEBOUNCE_CYCLES, 500000, clock cycles key level must stay stable before it is accepted (10 ms at 50 MHz). Must be >= 2.

Ports:
- clk  input  1  system clock (50 MHz on DE2).
- rst  input  1  synchronous, active-high reset.
- key_n  input  1  raw pushbutton, low = pressed, asynchronous to clk.
- sw  input  WIDTH  raw slide switches, asynchronous to clk.
- ready  input  1  downstream accepts data_out this cycle when valid=1.
- data_out  output  WIDTH  captured nibble.
- valid  output  1  data_out holds an unconsumed capture.
- overrun  output  1  sticky; a press was dropped because valid=1 and ready=0.
- capture_count  output  8  number of accepted captures, wraps 255->0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - data_out=0, valid=0, overrun=0, capture_count=0.
  - Synchronizer flops reset to idle levels (key high, sw 0).
  - Debounced key state = released; debounce counter = 0; FSM = IDLE.
- Synchronizer:
  - key_n and each sw bit pass through SYNC_STAGES flops.
  - Only the synchronized values are used internally.
- Debounce counter:
  - Counts while synced key differs from the debounced state.
  - Resets to 0 on any cycle where they are equal.
  - When it reaches DEBOUNCE_CYCLES-1 with inputs still differing, the debounced state toggles on the next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no state change.
- press_evt: one-cycle pulse on the debounced released->pressed transition. Release generates no event.
- FSM, release tracking: states IDLE, PRESSED.
  - IDLE -> PRESSED on press_evt.
  - PRESSED -> IDLE on debounced release.
  - A held key yields exactly one press_evt.
- Output register, on press_evt:
  - If valid=0, or valid=1 and ready=1 in the same cycle: data_out <= synced sw, valid <= 1, capture_count <= capture_count+1 (mod 256).
  - If valid=1 and ready=0: capture dropped. data_out and capture_count unchanged, overrun <= 1.
- Output register, without press_evt: valid=1 and ready=1 gives valid <= 0 next cycle; data_out holds its last value.
- Latency: valid rises exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges after the first edge sampling key_n low, if key_n stays low throughout.
- data_out stability: changes only on an accepted capture, never while valid=1 and ready=0.
- ready while valid=0: ignored.
- overrun: cleared only by rst.
- Reset mid-debounce or mid-handshake: all state returns to reset values on that edge. A key still held after reset must first debounce as pressed to produce an event; the reset value of the debounced state is released.

Decomposition:
- Shared package (de2_io_pkg):
  - CLK_HZ = 50000000.
  - DEBOUNCE_MS = 10.
  - Derived DEBOUNCE_CYCLES default.
  - FSM state enum {IDLE, PRESSED}.
- Sub-module key_debounce (one instance):
  - Contains the synchronizer plus debounce counter.
  - Outputs the debounced level and press_evt.
  - The top-level instantiates it, adds the sw synchronizer, FSM, output register, overrun and capture counter.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Clean capture: sw=4'b1011, key_n low held 20 cycles, ready=0 -> valid rises at edge 7 after key low; data_out=4'b1011; capture_count=1; stays valid while ready=0.
- Bounce rejection: key_n low 3 cycles, high 1, low 3, then high -> no press_evt, valid=0, capture_count=0.
- Handshake: from the clean-capture state, ready=1 for 1 cycle -> valid=0 next cycle, data_out stays 4'b1011; a second press with sw=4'b0110 -> data_out=4'b0110, capture_count=2.
- Overrun: valid=1, ready=0, second debounced press with sw=4'b0001 -> data_out unchanged, overrun=1, capture_count unchanged. Simultaneous press_evt and ready=1 -> new data latched, valid stays 1, count increments.
- Held key: key_n low 100 cycles -> exactly one capture; release then press again -> second capture.
- Reset/wrap: 256 accepted captures -> capture_count wraps to 0. rst asserted mid-debounce with key held -> all outputs 0; valid rises DEBOUNCE_CYCLES+SYNC_STAGES+1 edges after rst deasserts.

Source files
------------

// File: rtl/de2_io_pkg.sv
// ============================================================================
// Module : de2_io_pkg
// Brief  : Shared constants and FSM state type for the DE2 switch/key input chain.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package de2_io_pkg;

  localparam int CLK_HZ              = 50_000_000;
  localparam int DEBOUNCE_MS         = 10;
  localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module : key_debounce
// Brief  : Synchronizes an active-low pushbutton, debounces it, and emits a
//          one-cycle pulse on each debounced press.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce
  import de2_io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_pressed,
  output logic o_press_evt
);

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_key_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_pressed;
  logic                   r_press_evt;

  logic w_key_pressed;
  logic w_differ;
  logic w_settled;

  assign w_key_pressed = ~r_key_sync[SYNC_STAGES-1];
  assign w_differ      = (w_key_pressed != r_pressed);
  assign w_settled     = w_differ && (r_cnt == CNT_LAST);

  // Counter only advances while the synced level disagrees with the accepted
  // level, so any agreeing cycle restarts the stability window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_sync  <= '1;
      r_cnt       <= '0;
      r_pressed   <= 1'b0;
      r_press_evt <= 1'b0;
    end else begin
      r_key_sync  <= {r_key_sync[SYNC_STAGES-2:0], i_key_n};
      r_press_evt <= 1'b0;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_settled) begin
        r_cnt       <= '0;
        r_pressed   <= w_key_pressed;
        r_press_evt <= w_key_pressed;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pressed   = r_pressed;
  assign o_press_evt = r_press_evt;

endmodule

`default_nettype wire

// File: rtl/nibble_capture.sv
// ============================================================================
// Module : nibble_capture
// Brief  : Latches the synchronized switch nibble on each debounced key press
//          and offers it downstream through a valid/ready handshake.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_capture
  import de2_io_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             ready,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             overrun,
  output logic [7:0]       capture_count
);

  logic [WIDTH-1:0] r_sw_sync [SYNC_STAGES];
  cap_state_t       r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic [7:0]       r_count;

  logic w_pressed;
  logic w_press_evt;
  logic w_take;

  key_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk         (clk),
    .rst         (rst),
    .i_key_n     (key_n),
    .o_pressed   (w_pressed),
    .o_press_evt (w_press_evt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sw_sync[i] <= '0;
    end else begin
      r_sw_sync[0] <= sw;
      for (int i = 1; i < SYNC_STAGES; i++) r_sw_sync[i] <= r_sw_sync[i-1];
    end
  end

  // A press only counts from IDLE, so a held key can never re-trigger.
  assign w_take = w_press_evt && (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        IDLE:    if (w_press_evt) r_state <= PRESSED;
        PRESSED: if (!w_pressed)  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_take) begin
        if (!r_valid || ready) begin
          r_data  <= r_sw_sync[SYNC_STAGES-1];
          r_valid <= 1'b1;
          r_count <= r_count + 8'd1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out      = r_data;
  assign valid         = r_valid;
  assign overrun       = r_overrun;
  assign capture_count = r_count;

endmodule

`default_nettype wire
